// File: rtl/mem_port_resp_model.sv
// Multi-channel memory responder: NCH requester ports share one word-addressed store,
// with round-robin request arbitration and a fixed response latency per channel.
module mem_port_resp_model #(
  parameter int NCH     = 4,
  parameter int DATAW   = 32,
  parameter int ADDRW   = 32,
  parameter int SIZEW   = 4,
  parameter int DEPTHW  = 8,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         mem_valid,
  output logic [NCH-1:0]         mem_ready,
  input  logic [NCH*ADDRW-1:0]   mem_address,
  input  logic [NCH-1:0]         mem_wr_en,
  input  logic [NCH*DATAW-1:0]   mem_wr_data,
  input  logic [NCH*SIZEW-1:0]   mem_wr_size,
  output logic [NCH-1:0]         mem_dp_valid,
  input  logic [NCH-1:0]         mem_dp_ready,
  output logic [NCH*DATAW-1:0]   mem_dp_read_data,
  output logic [15:0]            req_count,
  output logic                   busy
);

  localparam int NB = DATAW / 8;
  localparam int B  = (NB > 1) ? $clog2(NB) : 0;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                 state_q [NCH];
  logic [3:0]             cnt_q   [NCH];
  logic [DATAW-1:0]       rdata_q [NCH];
  logic [NCH-1:0]         dp_valid_q;
  logic [CW-1:0]          rr_q;
  logic [15:0]            req_count_q;
  logic                   busy_q;
  logic                   busy_d;
  logic [DATAW-1:0]       store_q [2**DEPTHW];

  logic                   gnt_any;
  logic [CW-1:0]          gnt_idx;
  logic [CW-1:0]          cand;
  logic [DEPTHW-1:0]      g_word;
  logic [DATAW-1:0]       g_wdata;
  logic [SIZEW-1:0]       g_size;
  logic                   g_wr;
  logic                   full_wr;
  logic                   unused_addr;

  // Round-robin search from rr_q; only IDLE channels with a pending request are eligible.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    mem_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = CW'((int'(rr_q) + i) % NCH);
      if (!gnt_any && !reset && mem_valid[cand] && state_q[cand] == IDLE) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) mem_ready[gnt_idx] = 1'b1;
  end

  assign g_word      = mem_address[int'(gnt_idx)*ADDRW + B +: DEPTHW];
  assign g_wdata     = mem_wr_data[int'(gnt_idx)*DATAW +: DATAW];
  assign g_size      = mem_wr_size[int'(gnt_idx)*SIZEW +: SIZEW];
  assign g_wr        = mem_wr_en[gnt_idx];
  assign full_wr     = (g_size == '0) || (int'(g_size) > NB);
  assign unused_addr = ^mem_address;

  always_comb begin
    busy_d = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      case (state_q[c])
        IDLE:    if (gnt_any && gnt_idx == CW'(c)) busy_d = 1'b1;
        WAIT:    busy_d = 1'b1;
        RESP:    if (!(dp_valid_q[c] && mem_dp_ready[c])) busy_d = 1'b1;
        default: ;
      endcase
    end
  end

  // dp_valid is a registered stage behind RESP, which accounts for the extra cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        rdata_q[c] <= '0;
      end
      dp_valid_q  <= '0;
      rr_q        <= '0;
      req_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        case (state_q[c])
          IDLE: begin
            if (gnt_any && gnt_idx == CW'(c)) begin
              rdata_q[c] <= g_wr ? '0 : store_q[g_word];
              if (LATENCY == 0) begin
                state_q[c] <= RESP;
              end else begin
                state_q[c] <= WAIT;
                cnt_q[c]   <= 4'(LATENCY - 1);
              end
            end
          end
          WAIT: begin
            if (cnt_q[c] == '0) state_q[c] <= RESP;
            else                cnt_q[c]   <= cnt_q[c] - 4'd1;
          end
          RESP: begin
            if (dp_valid_q[c] && mem_dp_ready[c]) begin
              state_q[c]    <= IDLE;
              dp_valid_q[c] <= 1'b0;
            end else begin
              dp_valid_q[c] <= 1'b1;
            end
          end
          default: state_q[c] <= IDLE;
        endcase
      end
      if (gnt_any) begin
        rr_q <= CW'((int'(gnt_idx) + 1) % NCH);
        if (req_count_q != 16'hFFFF) req_count_q <= req_count_q + 16'd1;
      end
      busy_q <= busy_d;
    end
  end

  // The store is deliberately left out of reset so accepted writes survive it.
  always_ff @(posedge clk) begin
    if (gnt_any && g_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (full_wr || b < int'(g_size)) store_q[g_word][b*8 +: 8] <= g_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    mem_dp_read_data = '0;
    for (int c = 0; c < NCH; c++) mem_dp_read_data[c*DATAW +: DATAW] = rdata_q[c];
  end

  assign mem_dp_valid = dp_valid_q;
  assign req_count    = req_count_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_port_resp_model.sv
// Directed bench for mem_port_resp_model: a transaction table plus hand-written
// sequences for round robin, backpressure and reset in the middle of a request.
module tb_mem_port_resp_model;

  localparam int NCH = 4, DATAW = 32, ADDRW = 32, SIZEW = 4, DEPTHW = 8, LAT = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH-1:0]       mem_valid = '0;
  logic [NCH-1:0]       mem_ready;
  logic [NCH*ADDRW-1:0] mem_address = '0;
  logic [NCH-1:0]       mem_wr_en = '0;
  logic [NCH*DATAW-1:0] mem_wr_data = '0;
  logic [NCH*SIZEW-1:0] mem_wr_size = '0;
  logic [NCH-1:0]       mem_dp_valid;
  logic [NCH-1:0]       mem_dp_ready = '0;
  logic [NCH*DATAW-1:0] mem_dp_read_data;
  logic [15:0]          req_count;
  logic                 busy;

  int nChecks = 0;
  int nFails = 0;
  int expCount = 0;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  size;
    logic [31:0] expData;
  } txn_t;

  txn_t vecs[$];

  mem_port_resp_model #(
    .NCH(NCH), .DATAW(DATAW), .ADDRW(ADDRW), .SIZEW(SIZEW), .DEPTHW(DEPTHW), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_address(mem_address),
    .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .mem_wr_size(mem_wr_size),
    .mem_dp_valid(mem_dp_valid),
    .mem_dp_ready(mem_dp_ready),
    .mem_dp_read_data(mem_dp_read_data),
    .req_count(req_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request on one channel with dp_ready held high.
  task automatic applyStimulus(input txn_t t);
    int waitCyc;
    int lat;
    mem_valid = '0;
    mem_dp_ready = '1;
    mem_valid[t.ch] = 1'b1;
    mem_wr_en[t.ch] = t.wr;
    mem_address[t.ch*ADDRW +: ADDRW] = t.addr;
    mem_wr_data[t.ch*DATAW +: DATAW] = t.wdata;
    mem_wr_size[t.ch*SIZEW +: SIZEW] = t.size;
    #1;
    waitCyc = 0;
    while (!mem_ready[t.ch] && waitCyc < 20) begin
      tick();
      waitCyc++;
    end
    checkOutput($sformatf("grant ch%0d", t.ch), 32'(mem_ready[t.ch]), 32'd1);
    if (!mem_ready[t.ch]) begin
      mem_valid = '0;
      return;
    end
    tick();
    mem_valid[t.ch] = 1'b0;
    mem_wr_en[t.ch] = 1'b0;
    expCount++;
    lat = 0;
    while (!mem_dp_valid[t.ch] && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput($sformatf("latency ch%0d", t.ch), 32'(lat), 32'(LAT + 1));
    checkOutput($sformatf("rdata ch%0d addr %08h", t.ch, t.addr),
                mem_dp_read_data[t.ch*DATAW +: DATAW], t.expData);
    checkOutput("req_count", 32'(req_count), 32'(expCount));
    tick();
    checkOutput($sformatf("dp_valid drop ch%0d", t.ch), 32'(mem_dp_valid[t.ch]), 32'd0);
    checkOutput("busy after resp", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    checkOutput("reset ready", 32'(mem_ready), 32'd0);
    checkOutput("reset dp_valid", 32'(mem_dp_valid), 32'd0);
    checkOutput("reset rdata ch0", mem_dp_read_data[31:0], 32'd0);
    checkOutput("reset req_count", 32'(req_count), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    vecs.push_back('{0, 32'h0000_0040, 1'b1, 32'hDEADBEEF, 4'd4, 32'h0});
    vecs.push_back('{0, 32'h0000_0040, 1'b0, 32'h0,        4'd0, 32'hDEADBEEF});
    vecs.push_back('{1, 32'h0000_0080, 1'b1, 32'h11223344, 4'd0, 32'h0});
    vecs.push_back('{1, 32'h0000_0080, 1'b1, 32'hAABBCCDD, 4'd2, 32'h0});
    vecs.push_back('{1, 32'h0000_0080, 1'b0, 32'h0,        4'd0, 32'h1122CCDD});
    vecs.push_back('{2, 32'h0000_0004, 1'b1, 32'h0000_0005, 4'd4, 32'h0});
    vecs.push_back('{3, 32'h0000_0404, 1'b0, 32'h0,        4'd0, 32'h0000_0005});
    vecs.push_back('{2, 32'h0000_00C0, 1'b1, 32'hFFFFFFFF, 4'd4, 32'h0});
    vecs.push_back('{3, 32'h0000_00C0, 1'b1, 32'h0000_0012, 4'd1, 32'h0});
    vecs.push_back('{0, 32'h0000_00C0, 1'b0, 32'h0,        4'd0, 32'hFFFFFF12});
    vecs.push_back('{1, 32'h0000_00C0, 1'b1, 32'hCAFEF00D, 4'd5, 32'h0});
    vecs.push_back('{2, 32'h0000_00C3, 1'b0, 32'h0,        4'd0, 32'hCAFEF00D});
    vecs.push_back('{3, 32'h1234_0040, 1'b0, 32'h0,        4'd0, 32'hDEADBEEF});
    vecs.push_back('{0, 32'h0000_00C0, 1'b1, 32'h99887766, 4'd3, 32'h0});
    vecs.push_back('{0, 32'h0000_00C0, 1'b0, 32'h0,        4'd0, 32'hCA887766});
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Round robin: every channel requests from reset release, nobody takes responses.
    reset = 1'b1;
    mem_valid = '1;
    mem_wr_en = '0;
    mem_address = '0;
    mem_dp_ready = '0;
    tick();
    tick();
    checkOutput("ready during reset", 32'(mem_ready), 32'd0);
    reset = 1'b0;
    expCount = 0;
    #1;
    for (int i = 0; i < NCH; i++) begin
      checkOutput($sformatf("rr order step %0d", i), 32'(mem_ready), 32'(1 << i));
      tick();
      expCount++;
    end
    for (int i = 0; i < 6; i++) begin
      checkOutput("all busy ready", 32'(mem_ready), 32'd0);
      tick();
    end
    checkOutput("all busy flag", 32'(busy), 32'd1);
    checkOutput("all dp_valid", 32'(mem_dp_valid), 32'hF);
    mem_dp_ready[0] = 1'b1;
    #1;
    checkOutput("ch0 before handshake", 32'(mem_ready), 32'd0);
    tick();
    checkOutput("ch0 after handshake", 32'(mem_ready), 32'd1);
    mem_valid = '0;
    mem_dp_ready = '1;
    tick();
    tick();
    checkOutput("rr drained busy", 32'(busy), 32'd0);
    checkOutput("rr req_count", 32'(req_count), 32'(expCount));

    // Backpressure on ch2 while ch0 continues to be served.
    mem_dp_ready = 4'b1011;
    mem_valid[2] = 1'b1;
    mem_address[2*ADDRW +: ADDRW] = 32'h40;
    #1;
    for (int w = 0; w < 20 && !mem_ready[2]; w++) tick();
    checkOutput("bp grant ch2", 32'(mem_ready[2]), 32'd1);
    tick();
    expCount++;
    repeat (3) tick();
    mem_valid[0] = 1'b1;
    mem_address[0 +: ADDRW] = 32'h80;
    #1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp dp_valid ch2", 32'(mem_dp_valid[2]), 32'd1);
      checkOutput("bp rdata ch2", mem_dp_read_data[2*DATAW +: DATAW], 32'hDEADBEEF);
      checkOutput("bp ready ch2", 32'(mem_ready[2]), 32'd0);
      if (i == 0) checkOutput("bp ready ch0", 32'(mem_ready[0]), 32'd1);
      if (i == 4) begin
        checkOutput("bp dp_valid ch0", 32'(mem_dp_valid[0]), 32'd1);
        checkOutput("bp rdata ch0", mem_dp_read_data[0 +: DATAW], 32'h1122CCDD);
      end
      tick();
      if (i == 0) begin
        mem_valid[0] = 1'b0;
        expCount++;
      end
      #1;
    end
    mem_valid[2] = 1'b0;
    mem_dp_ready[2] = 1'b1;
    tick();
    checkOutput("bp release ch2", 32'(mem_dp_valid[2]), 32'd0);
    checkOutput("bp req_count", 32'(req_count), 32'(expCount));

    // Reset while ch3 is waiting on its response.
    mem_valid[3] = 1'b1;
    mem_address[3*ADDRW +: ADDRW] = 32'h80;
    #1;
    for (int w = 0; w < 20 && !mem_ready[3]; w++) tick();
    checkOutput("mid-reset grant ch3", 32'(mem_ready[3]), 32'd1);
    tick();
    mem_valid[3] = 1'b0;
    tick();
    checkOutput("ch3 waiting busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("mid-reset dp_valid", 32'(mem_dp_valid), 32'd0);
    checkOutput("mid-reset busy", 32'(busy), 32'd0);
    checkOutput("mid-reset req_count", 32'(req_count), 32'd0);
    reset = 1'b0;
    expCount = 0;
    applyStimulus('{1, 32'h0000_0040, 1'b0, 32'h0, 4'd0, 32'hDEADBEEF});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
